// File: rtl/membus_pkg.sv
// Shared definitions for the PDP-6 memory-bus to Avalon bridge.
//   MB_W      : memory word width (36-bit data)
//   MA_W      : memory address width (18-bit word address)
//   state_e   : bridge sequencing states
//   in_window : true when an address falls in the window served by base
package membus_pkg;

  localparam int MB_W = 36;
  localparam int MA_W = 18;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RDRS,
    WWAIT,
    WR,
    DONE
  } state_e;

  // The window is aligned to 2**size_log2, so matching the bits above the
  // window size is the whole test.
  function automatic logic in_window(input logic [MA_W-1:0] ma,
                                     input logic [MA_W-1:0] base,
                                     input int              size_log2);
    return (ma >> size_log2) == (base >> size_log2);
  endfunction

endpackage

// File: rtl/membus_edge.sv
// Rising-edge detector.
//   i_clk   : clock
//   i_reset : asynchronous active-high reset
//   i_sig   : level input
//   o_rise  : high for the cycle in which i_sig is high after a low sample
module membus_edge (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sig,
  output logic o_rise
);

  logic prev_q, prev_d;

  always_comb begin
    prev_d = i_sig;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) prev_q <= 1'b0;
    else         prev_q <= prev_d;
  end

  assign o_rise = i_sig & ~prev_q;

endmodule

// File: rtl/membus_avalon_bridge.sv
// Memory-side front end of the PDP-6 memory bus. Each accepted bus cycle
// becomes a single-word Avalon read and/or write toward a 36-bit slave.
//   i_clk, i_reset           : clock, asynchronous active-high reset
//   i_membus_*               : processor cycle request, address, write data
//   o_membus_addr_ack        : one-cycle pulse, cycle accepted
//   o_membus_rd_rs           : one-cycle pulse, read data valid on mb_out
//   o_membus_mb_out          : read data register
//   o_address/o_read/o_write/o_writedata, i_readdata/i_waitrequest : Avalon
//
// state | meaning
// IDLE  | waiting for a new in-window cycle
// RD    | Avalon read in flight
// RDRS  | read restart pulse to the bus
// WWAIT | waiting for write restart with write data
// WR    | Avalon write in flight
// DONE  | cycle finished, waiting for rq_cyc to drop
module membus_avalon_bridge
  import membus_pkg::*;
#(
  parameter logic [MA_W-1:0] BASE      = 18'o0,
  parameter int              SIZE_LOG2 = 14
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_membus_rq_cyc,
  input  logic            i_membus_rd_rq,
  input  logic            i_membus_wr_rq,
  input  logic [MA_W-1:0] i_membus_ma,
  input  logic            i_membus_wr_rs,
  input  logic [MB_W-1:0] i_membus_mb_in,
  output logic            o_membus_addr_ack,
  output logic            o_membus_rd_rs,
  output logic [MB_W-1:0] o_membus_mb_out,
  output logic [MA_W-1:0] o_address,
  output logic            o_read,
  output logic            o_write,
  output logic [MB_W-1:0] o_writedata,
  input  logic [MB_W-1:0] i_readdata,
  input  logic            i_waitrequest
);

  state_e          state_q, state_d;
  logic [MA_W-1:0] ma_q, ma_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic            addr_ack_q, addr_ack_d;
  logic            rd_rs_q, rd_rs_d;
  logic            read_q, read_d;
  logic            write_q, write_d;
  logic [MB_W-1:0] mb_out_q, mb_out_d;
  logic [MB_W-1:0] wdata_q, wdata_d;
  logic            rq_rise;
  logic            accept;

  // Only a fresh rq_cyc is accepted, so a cycle still held after DONE is
  // not taken a second time.
  membus_edge u_rq_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_sig   (i_membus_rq_cyc),
    .o_rise  (rq_rise)
  );

  assign accept = rq_rise & (i_membus_rd_rq | i_membus_wr_rq) &
                  in_window(i_membus_ma, BASE, SIZE_LOG2);

  always_comb begin
    state_d  = state_q;
    ma_d     = ma_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    mb_out_d = mb_out_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ma_d    = i_membus_ma;
          rd_d    = i_membus_rd_rq;
          wr_d    = i_membus_wr_rq;
          state_d = i_membus_rd_rq ? RD : WWAIT;
        end
      end
      RD: begin
        // The slave transfer always completes; an aborted cycle just skips
        // the restart pulse.
        if (!i_waitrequest) begin
          mb_out_d = i_readdata;
          state_d  = i_membus_rq_cyc ? RDRS : IDLE;
        end
      end
      RDRS: begin
        if (!i_membus_rq_cyc) state_d = IDLE;
        else if (wr_q)        state_d = WWAIT;
        else                  state_d = DONE;
      end
      WWAIT: begin
        if (!i_membus_rq_cyc) begin
          state_d = IDLE;
        end else if (i_membus_wr_rs) begin
          wdata_d = i_membus_mb_in;
          state_d = WR;
        end
      end
      WR: begin
        if (!i_waitrequest) state_d = i_membus_rq_cyc ? DONE : IDLE;
      end
      DONE: begin
        if (!i_membus_rq_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the
    // first cycle of the state they belong to.
    addr_ack_d = (state_q == IDLE) && accept;
    rd_rs_d    = (state_d == RDRS);
    read_d     = (state_d == RD);
    write_d    = (state_d == WR);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      ma_q       <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_ack_q <= 1'b0;
      rd_rs_q    <= 1'b0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      mb_out_q   <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ma_q       <= ma_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_ack_q <= addr_ack_d;
      rd_rs_q    <= rd_rs_d;
      read_q     <= read_d;
      write_q    <= write_d;
      mb_out_q   <= mb_out_d;
      wdata_q    <= wdata_d;
    end
  end

  assign o_membus_addr_ack = addr_ack_q;
  assign o_membus_rd_rs    = rd_rs_q;
  assign o_membus_mb_out   = mb_out_q;
  // Window is aligned, so the offset has zero upper bits for any accepted ma.
  assign o_address         = ma_q - BASE;
  assign o_read            = read_q;
  assign o_write           = write_q;
  assign o_writedata       = wdata_q;

endmodule

// File: tb/tb_membus_avalon_bridge.sv
module tb_membus_avalon_bridge;

  logic        clk;
  logic        rst;
  logic        rq_cyc, rd_rq, wr_rq, wr_rs;
  logic [17:0] ma;
  logic [35:0] mb_in;
  logic        addr_ack, rd_rs;
  logic [35:0] mb_out;
  logic [17:0] av_addr;
  logic        av_read, av_write;
  logic [35:0] av_wdata, av_rdata;
  logic        av_wait;

  int          n_total = 0;
  int          n_bad   = 0;

  // Avalon slave model
  logic [35:0] mem [0:262143];
  int          wait_cycles = 0;
  int          wcnt = 0;
  int          n_reads = 0;
  int          n_writes = 0;

  // Per-run observation, bit k = value seen in cycle k after acceptance edge
  logic [31:0] ack_m, rd_m, wr_m, rs_m;
  logic [35:0] rs_data, wd_seen;
  logic [17:0] addr_seen;
  logic        both_seen;

  membus_avalon_bridge dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_membus_rq_cyc   (rq_cyc),
    .i_membus_rd_rq    (rd_rq),
    .i_membus_wr_rq    (wr_rq),
    .i_membus_ma       (ma),
    .i_membus_wr_rs    (wr_rs),
    .i_membus_mb_in    (mb_in),
    .o_membus_addr_ack (addr_ack),
    .o_membus_rd_rs    (rd_rs),
    .o_membus_mb_out   (mb_out),
    .o_address         (av_addr),
    .o_read            (av_read),
    .o_write           (av_write),
    .o_writedata       (av_wdata),
    .i_readdata        (av_rdata),
    .i_waitrequest     (av_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign av_wait  = (av_read | av_write) && (wcnt < wait_cycles);
  assign av_rdata = mem[av_addr];

  always @(posedge clk) begin
    if (av_read && !av_wait) n_reads = n_reads + 1;
    if (av_write && !av_wait) begin
      mem[av_addr] = av_wdata;
      n_writes = n_writes + 1;
    end
    if ((av_read || av_write) && av_wait) wcnt <= wcnt + 1;
    else                                  wcnt <= 0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a negedge. Issues one bus cycle and observes ncyc
  // cycles; wr_rs is driven in cycle wrs_cyc, rq_cyc drops from drop_cyc.
  task automatic run_cyc(input logic rd, input logic wr, input logic [17:0] a,
                         input int wrs_cyc, input logic [35:0] wd,
                         input int ncyc, input int drop_cyc);
    ack_m = '0; rd_m = '0; wr_m = '0; rs_m = '0;
    rs_data = '0; wd_seen = '0; addr_seen = '0; both_seen = 1'b0;
    rq_cyc = 1'b1; rd_rq = rd; wr_rq = wr; ma = a;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      ack_m[c] = addr_ack;
      rd_m[c]  = av_read;
      wr_m[c]  = av_write;
      rs_m[c]  = rd_rs;
      if (av_read && av_write) both_seen = 1'b1;
      if (rd_rs) rs_data = mb_out;
      if (av_write && wd_seen == '0) wd_seen = av_wdata;
      if ((av_read || av_write) && addr_seen == '0) addr_seen = av_addr;
      wr_rs = (c == wrs_cyc);
      mb_in = (c == wrs_cyc) ? wd : 36'o0;
      if (drop_cyc != 0 && c >= drop_cyc) rq_cyc = 1'b0;
    end
    rq_cyc = 1'b0; rd_rq = 1'b0; wr_rq = 1'b0; wr_rs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int r0, w0;
    rst = 1'b1;
    rq_cyc = 1'b0; rd_rq = 1'b0; wr_rq = 1'b0; wr_rs = 1'b0;
    ma = '0; mb_in = '0;
    for (int i = 0; i < 262144; i++) mem[i] = '0;
    mem[18'o100] = 36'o123456701234;
    mem[18'o5]   = 36'o1;

    repeat (3) @(negedge clk);
    check("rst_ack",    {63'd0, addr_ack}, 64'd0);
    check("rst_rdrs",   {63'd0, rd_rs},    64'd0);
    check("rst_mbout",  {28'd0, mb_out},   64'd0);
    check("rst_addr",   {46'd0, av_addr},  64'd0);
    check("rst_read",   {63'd0, av_read},  64'd0);
    check("rst_write",  {63'd0, av_write}, 64'd0);
    check("rst_wdata",  {28'd0, av_wdata}, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Read, W=4
    wait_cycles = 4;
    run_cyc(1'b1, 1'b0, 18'o100, 0, 36'o0, 8, 0);
    check("rd_ack",   {32'd0, ack_m}, 64'h2);
    check("rd_read",  {32'd0, rd_m},  64'h3E);
    check("rd_write", {32'd0, wr_m},  64'h0);
    check("rd_rs",    {32'd0, rs_m},  64'h40);
    check("rd_addr",  {46'd0, addr_seen}, 64'o100);
    check("rd_data",  {28'd0, rs_data}, 64'o123456701234);
    check("rd_mbhold", {28'd0, mb_out}, 64'o123456701234);

    // Write, W=4, wr_rs at cycle 3
    run_cyc(1'b0, 1'b1, 18'o37777, 3, 36'o777777777777, 10, 0);
    check("wr_ack",   {32'd0, ack_m}, 64'h2);
    check("wr_write", {32'd0, wr_m},  64'h1F0);
    check("wr_read",  {32'd0, rd_m},  64'h0);
    check("wr_rs",    {32'd0, rs_m},  64'h0);
    check("wr_wdata", {28'd0, wd_seen}, 64'o777777777777);
    check("wr_mem",   {28'd0, mem[18'o37777]}, 64'o777777777777);

    // Read-modify-write, W=2, wr_rs two cycles after rd_rs
    wait_cycles = 2;
    r0 = n_reads; w0 = n_writes;
    run_cyc(1'b1, 1'b1, 18'o5, 6, 36'o2, 11, 0);
    check("rmw_read",  {32'd0, rd_m}, 64'hE);
    check("rmw_rs",    {32'd0, rs_m}, 64'h10);
    check("rmw_write", {32'd0, wr_m}, 64'h380);
    check("rmw_data",  {28'd0, rs_data}, 64'o1);
    check("rmw_mem",   {28'd0, mem[18'o5]}, 64'o2);
    check("rmw_nrd",   64'(n_reads - r0), 64'd1);
    check("rmw_nwr",   64'(n_writes - w0), 64'd1);
    check("rmw_excl",  {63'd0, both_seen}, 64'd0);

    // Out of window
    run_cyc(1'b1, 1'b0, 18'o40000, 0, 36'o0, 6, 0);
    check("oow_ack",   {32'd0, ack_m}, 64'h0);
    check("oow_read",  {32'd0, rd_m},  64'h0);
    check("oow_write", {32'd0, wr_m},  64'h0);

    // Abort during read at cycle 2, W=4
    wait_cycles = 4;
    run_cyc(1'b1, 1'b0, 18'o100, 0, 36'o0, 8, 2);
    check("ab_ack",  {32'd0, ack_m}, 64'h2);
    check("ab_read", {32'd0, rd_m},  64'h3E);
    check("ab_rs",   {32'd0, rs_m},  64'h0);

    // Next cycle after abort, W=0: read back the earlier write
    wait_cycles = 0;
    run_cyc(1'b1, 1'b0, 18'o37777, 0, 36'o0, 5, 0);
    check("nx_read", {32'd0, rd_m}, 64'h2);
    check("nx_rs",   {32'd0, rs_m}, 64'h4);
    check("nx_data", {28'd0, rs_data}, 64'o777777777777);

    // Reset during WR
    wait_cycles = 4;
    rq_cyc = 1'b1; wr_rq = 1'b1; ma = 18'o10;
    @(negedge clk);
    @(negedge clk);
    wr_rs = 1'b1; mb_in = 36'o555;
    @(negedge clk);
    wr_rs = 1'b0; mb_in = '0;
    check("rs_wr_on", {63'd0, av_write}, 64'd1);
    @(negedge clk);
    rst = 1'b1; rq_cyc = 1'b0; wr_rq = 1'b0;
    #1;
    check("rs_write", {63'd0, av_write}, 64'd0);
    check("rs_read",  {63'd0, av_read},  64'd0);
    check("rs_wdata", {28'd0, av_wdata}, 64'd0);
    check("rs_mbout", {28'd0, mb_out},   64'd0);
    check("rs_ack",   {63'd0, addr_ack}, 64'd0);
    check("rs_addr",  {46'd0, av_addr},  64'd0);
    check("rs_mem",   {28'd0, mem[18'o10]}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wait_cycles = 1;
    run_cyc(1'b1, 1'b0, 18'o100, 0, 36'o0, 6, 0);
    check("pr_ack",  {32'd0, ack_m}, 64'h2);
    check("pr_read", {32'd0, rd_m},  64'h6);
    check("pr_rs",   {32'd0, rs_m},  64'h8);
    check("pr_data", {28'd0, rs_data}, 64'o123456701234);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
